regfile_param: RTL

- Parametrised multi-port register file for the single-cycle/pipelined CPU datapath; successor to the fixed 32x32 register file.
- Provides 2 registered read ports, 1 write port, optional hardwired-zero register 0, and optional write-to-read bypass.
- Adds a per-register busy scoreboard for hazard detection and a sequenced bulk-clear engine.
- Sits between the decode stage (read addresses) and the writeback stage (write port).

---
 rtl/regfile_param_if.sv | 30 +++
 rtl/regfile_param.sv | 116 +++++++++++
 2 files changed

// File: rtl/regfile_param_if.sv
// rtl/regfile_param_if.sv - register file read/write, scoreboard and bulk-clear signal bundle
interface regfile_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              busy1;
    logic              busy2;
    logic              sb_set;
    logic [ADDR_W-1:0] sb_addr;
    logic              clr_req;
    logic              clr_busy;
    logic              clr_done;

    modport master (
        output we, wa, wd, ra1, ra2, sb_set, sb_addr, clr_req,
        input  rd1, rd2, busy1, busy2, clr_busy, clr_done
    );

    modport slave (
        input  we, wa, wd, ra1, ra2, sb_set, sb_addr, clr_req,
        output rd1, rd2, busy1, busy2, clr_busy, clr_done
    );
endinterface

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - 2R/1W register file with busy scoreboard and sequenced bulk clear
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    regfile_param_if.slave bus
);
    localparam int              DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST  = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE   = (ADDR_W + 1)'(1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, next_state;
    logic [ADDR_W:0]   cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              clr_done_q;

    logic              idle, start_clr, last_clr;
    logic              wr_ok, sb_ok;
    logic              byp1, byp2, zero1, zero2;
    logic [DATA_W-1:0] rd1_nxt, rd2_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        idle       = 1'b0;
        start_clr  = 1'b0;
        last_clr   = 1'b0;
        case (state)
            IDLE: begin
                idle = 1'b1;
                if (bus.clr_req) begin
                    next_state = CLEAR;
                    start_clr  = 1'b1;
                end
            end
            CLEAR: begin
                if (cnt == LAST) begin
                    last_clr   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Writes and scoreboard sets are only honoured outside the clear sequence.
    always_comb begin
        wr_ok = idle && bus.we && !((ZERO_REG != 0) && (bus.wa == '0));
        sb_ok = idle && bus.sb_set && !((ZERO_REG != 0) && (bus.sb_addr == '0));
        zero1 = (ZERO_REG != 0) && (bus.ra1 == '0);
        zero2 = (ZERO_REG != 0) && (bus.ra2 == '0);
        byp1  = (BYPASS != 0) && wr_ok && (bus.wa == bus.ra1);
        byp2  = (BYPASS != 0) && wr_ok && (bus.wa == bus.ra2);
        rd1_nxt = zero1 ? '0 : (byp1 ? bus.wd : mem[bus.ra1]);
        rd2_nxt = zero2 ? '0 : (byp2 ? bus.wd : mem[bus.ra2]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            clr_done_q <= 1'b0;
        end else begin
            clr_done_q <= last_clr;
            if (start_clr)          cnt <= '0;
            else if (state == CLEAR) cnt <= cnt + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (state == CLEAR) begin
            mem[cnt[ADDR_W-1:0]] <= '0;
        end else if (wr_ok) begin
            mem[bus.wa] <= bus.wd;
        end
    end

    // A set on the same address as a completing write wins, so it is applied last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else if (start_clr) begin
            busy <= '0;
        end else begin
            if (wr_ok) busy[bus.wa]      <= 1'b0;
            if (sb_ok) busy[bus.sb_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rd1 <= '0;
            bus.rd2 <= '0;
        end else begin
            bus.rd1 <= rd1_nxt;
            bus.rd2 <= rd2_nxt;
        end
    end

    assign bus.busy1    = busy[bus.ra1];
    assign bus.busy2    = busy[bus.ra2];
    assign bus.clr_busy = (state == CLEAR);
    assign bus.clr_done = clr_done_q;
endmodule
